// File: rtl/vga_fb_arbiter.sv
// Frame-buffer port arbiter: display fetch has priority, one writer is served in blanking.
// Optional VGA_ARB_VBLANK_ONLY_EN restricts writes to vertical blanking.
module vga_fb_arbiter #(
  parameter int AW = 19,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ready,
  input  logic [10:0]   column_addr_sig,
  input  logic [10:0]   row_addr_sig,
  input  logic          hsync_sig,
  input  logic          vsnyc_sig,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  output logic          wr_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] pixel_data,
  output logic          pixel_valid,
  output logic          hsync_out,
  output logic          vsync_out
);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_t;

  localparam logic [AW-1:0] FB_WORDS = AW'(480000);

  state_t        state;
  logic          gate;
  logic          wr_in_range;
  logic          fetch_vld;
  logic [1:0]    hs_pipe;
  logic [1:0]    vs_pipe;
  logic [AW-1:0] row_w;
  logic [AW-1:0] rd_addr;

  // row*800 as shifts; 479999 fits AW bits so nothing is truncated
  assign row_w       = AW'(row_addr_sig);
  assign rd_addr     = (row_w << 9) + (row_w << 8) + (row_w << 5) + AW'(column_addr_sig);
  assign wr_in_range = (wr_addr < FB_WORDS);

`ifdef VGA_ARB_VBLANK_ONLY_EN
  logic vblank;

  always_ff @(posedge clk) begin
    if (!rst_n)          vblank <= 1'b0;
    else if (ready)      vblank <= 1'b0;
    else if (!vsnyc_sig) vblank <= 1'b1;
  end

  assign gate = vblank;
`else
  assign gate = !ready;
`endif

  // wr_ack=1 blocks a new grant so a late-dropped wr_req is not written twice
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      if (ready) begin
        state    <= ST_READ;
        mem_addr <= rd_addr;
      end else if (wr_req && gate && !wr_ack) begin
        state  <= ST_WRITE;
        wr_ack <= 1'b1;
        if (wr_in_range) begin
          mem_we    <= 1'b1;
          mem_addr  <= wr_addr;
          mem_wdata <= wr_data;
        end else begin
          wr_err <= 1'b1;
        end
      end else begin
        state <= ST_IDLE;
      end
    end
  end

  // sync delay matches the fetch pipe: both outputs move two edges after sampling
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_vld   <= 1'b0;
      pixel_valid <= 1'b0;
      pixel_data  <= '0;
      hs_pipe     <= 2'b11;
      vs_pipe     <= 2'b11;
      hsync_out   <= 1'b1;
      vsync_out   <= 1'b1;
    end else begin
      fetch_vld   <= (state == ST_READ);
      pixel_valid <= fetch_vld;
      pixel_data  <= fetch_vld ? mem_rdata : '0;
      hs_pipe     <= {hs_pipe[0], hsync_sig};
      vs_pipe     <= {vs_pipe[0], vsnyc_sig};
      hsync_out   <= hs_pipe[1];
      vsync_out   <= vs_pipe[1];
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: scan lines with random write traffic against a reference model.
module tb_vga_fb_arbiter;
  localparam int AW = 19, DW = 16, WORDS = 480000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ready = 1'b0;
  logic [10:0]   column_addr_sig = '0;
  logic [10:0]   row_addr_sig = '0;
  logic          hsync_sig = 1'b1;
  logic          vsnyc_sig = 1'b1;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack, wr_err, mem_we, pixel_valid, hsync_out, vsync_out;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, pixel_data;
  logic [DW-1:0] mem_rdata;

  vga_fb_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready),
    .column_addr_sig(column_addr_sig), .row_addr_sig(row_addr_sig),
    .hsync_sig(hsync_sig), .vsnyc_sig(vsnyc_sig),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  // pixel RAM the arbiter drives
  logic [DW-1:0] ram [0:524287];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    else        mem_rdata     <= ram[mem_addr];
  end

  // reference model
  logic [DW-1:0] ref_mem [0:WORDS-1];
  logic          hv [4], hhs [4], hvs [4];
  logic [DW-1:0] hp [4];
  int            ha [4];
  logic          exp_ack = 0, exp_err = 0, exp_we = 0, vb = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;

  int ncmp = 0, nerr = 0, cyc = 0;
  int nack = 0, nwerr = 0, last_ack = -10, wmode = 0;
  logic [DW-1:0] cap800 = '0, caplast = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic new_req();
    wr_req = 1'b1;
    if ($urandom_range(0, 5) == 0) wr_addr = AW'(WORDS + $urandom_range(0, 1000));
    else                           wr_addr = AW'($urandom_range(0, WORDS - 1));
    wr_data = DW'($urandom);
  endtask

  task automatic tick();
    int e, p, ra;
    logic rd, inr, elig, gate;
    e  = cyc & 3;
    rd = rst_n && ready;
    ra = int'(row_addr_sig) * 800 + int'(column_addr_sig);
    inr = int'(wr_addr) < WORDS;
`ifdef VGA_ARB_VBLANK_ONLY_EN
    gate = vb;
`else
    gate = 1'b1;
`endif
    elig = rst_n && !ready && wr_req && gate && !exp_ack;
    hv[e] = rd; hp[e] = rd ? ref_mem[ra] : '0; ha[e] = ra;
    hhs[e] = hsync_sig; hvs[e] = vsnyc_sig;
    if (rst_n) begin
      exp_ack = elig; exp_err = elig && !inr; exp_we = elig && inr;
      if (rd) exp_addr = AW'(ra);
      else if (exp_we) begin
        exp_addr = wr_addr; exp_wdata = wr_data; ref_mem[wr_addr] = wr_data;
      end
      if (ready) vb = 1'b0;
      else if (!vsnyc_sig) vb = 1'b1;
    end else begin
      exp_ack = 0; exp_err = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0; vb = 0;
      for (int k = 0; k < 3; k++) begin
        hv[(cyc - k) & 3] = 1'b0; hhs[(cyc - k) & 3] = 1'b1; hvs[(cyc - k) & 3] = 1'b1;
      end
    end
    @(posedge clk); #1;
    p = (cyc + 2) & 3;
    chk("pixel_valid", pixel_valid, hv[p]);
    chk("pixel_data", pixel_data, hv[p] ? hp[p] : '0);
    chk("hsync_out", hsync_out, hhs[p]);
    chk("vsync_out", vsync_out, hvs[p]);
    chk("wr_ack", wr_ack, exp_ack);
    chk("wr_err", wr_err, exp_err);
    chk("mem_we", mem_we, exp_we);
    chk("mem_addr", mem_addr, exp_addr);
    chk("mem_wdata", mem_wdata, exp_wdata);
    if (hv[p] && ha[p] == 800) cap800 = pixel_data;
    if (hv[p] && ha[p] == WORDS - 1) caplast = pixel_data;
    if (wr_ack) begin
      chk("ack_gap_ge2", (cyc - last_ack) >= 2, 1);
      last_ack = cyc;
      nack++;
      if (wr_err) nwerr++;
      if (wmode == 2) new_req();
      else wr_req = 1'b0;
    end
    cyc++;
  endtask

  task automatic line(input int r);
    for (int c = 0; c < 800; c++) begin
      ready = 1'b1; column_addr_sig = 11'(c); row_addr_sig = 11'(r);
      tick();
    end
    ready = 1'b0;
  endtask

  task automatic blank(input int n, input bit vs_pulse);
    for (int i = 0; i < n; i++) begin
      ready = 1'b0;
      column_addr_sig = 11'($urandom_range(0, 799));
      row_addr_sig = 11'($urandom_range(0, 599));
      hsync_sig = !(i >= 8 && i < 20);
      vsnyc_sig = !(vs_pulse && i >= 4 && i < 12);
      tick();
    end
    hsync_sig = 1'b1; vsnyc_sig = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      ram[i] <= DW'(i);
      ref_mem[i] = DW'(i);
    end
    for (int k = 0; k < 4; k++) begin hv[k] = 0; hhs[k] = 1; hvs[k] = 1; hp[k] = '0; ha[k] = 0; end

    // reset and idle
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    blank(30, 1'b1);

    // preloaded pixels at frame corners
    line(0); blank(40, 1'b0);
    line(1); blank(40, 1'b0);
    line(599); blank(40, 1'b0);
    chk("px_row1_col0", cap800, 16'd800);
    chk("px_row599_col799", caplast, 16'h52FF);

    // write held through active video, then blanking
    wmode = 1; nack = 0;
    wr_req = 1'b1; wr_addr = AW'(1234); wr_data = 16'hBEEF;
    line(5);
    chk("no_ack_in_active", nack, 0);
    blank(40, 1'b0);
`ifdef VGA_ARB_VBLANK_ONLY_EN
    chk("hblank_ack_cnt", nack, 0);
`else
    chk("hblank_ack_cnt", nack, 1);
`endif
    blank(30, 1'b1);
    chk("write_1234_once", nack, 1);
    line(1);
    blank(20, 1'b0);

    // out-of-range write
    nwerr = 0; nack = 0;
    wr_req = 1'b1; wr_addr = AW'(WORDS); wr_data = 16'h1111;
    blank(20, 1'b1);
    chk("oor_ack_cnt", nack, 1);
    chk("oor_err_cnt", nwerr, 1);

    // continuous random writes across lines and blanking
    wmode = 2; new_req();
    blank(60, 1'b1);
    for (int it = 0; it < 8; it++) begin
      line($urandom_range(0, 599));
      blank($urandom_range(20, 60), 1'($urandom_range(0, 1)));
    end
    wmode = 1; wr_req = 1'b0;
    blank(10, 1'b0);

    // reset landing on the write cycle, then on the grant edge
    blank(12, 1'b1);
    wr_req = 1'b1; wr_addr = AW'(77); wr_data = 16'h7777;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    blank(12, 1'b1);
    wr_req = 1'b1; wr_addr = AW'(78); rst_n = 1'b0;
    tick();
    rst_n = 1'b1; wr_req = 1'b0;
    blank(12, 1'b1);

    line(2);
    blank(10, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Single-port frame-buffer arbiter and pixel fetch sequencer for the 800x600@60Hz (40 MHz) display path. Sits between the VGA sync generator (ready, column/row address, hsync, vsync) and one synchronous single-port pixel RAM. Display reads have absolute priority; one write requester is granted only during blanking. Sync outputs are delayed to stay aligned with the fetched pixel.

## Interface
- AW, 19, frame-buffer address width; 800*600 = 480000 words.
- DW, 16, pixel data width.
- clk  in  1  40 MHz pixel clock.
- rst_n  in  1  reset: synchronous, active-low, sampled on rising clk.
- ready  in  1  sync-generator active-video flag.
- column_addr_sig  in  11  pixel column 0..799, valid while ready=1.
- row_addr_sig  in  11  pixel row 0..599, valid while ready=1.
- hsync_sig  in  1  horizontal sync, active-low.
- vsnyc_sig  in  1  vertical sync, active-low.
- wr_req  in  1  write request, level; held with wr_addr/wr_data until wr_ack.
- wr_addr  in  AW  linear write address.
- wr_data  in  DW  write data.
- wr_ack  out  1  one-cycle pulse: request consumed.
- wr_err  out  1  one-cycle pulse with wr_ack: address >= 480000, write dropped.
- mem_addr  out  AW  RAM address, registered.
- mem_we  out  1  RAM write enable, registered.
- mem_wdata  out  DW  RAM write data, registered.
- mem_rdata  in  DW  RAM read data, valid one cycle after mem_addr with mem_we=0.
- pixel_data  out  DW  pixel to DAC; 0 when pixel_valid=0.
- pixel_valid  out  1  pixel_data valid.
- hsync_out / vsync_out  out  1 each  hsync_sig / vsnyc_sig delayed 2 cycles.

## Operation
- Port owner FSM, state = owner of the RAM port in the current cycle: ST_IDLE, ST_READ, ST_WRITE. The next state is decided each cycle from registered inputs.
- Next state is ST_READ if ready=1.
- Otherwise it is ST_WRITE if wr_req=1, the write gate is open, and wr_ack=0 in this cycle.
- Otherwise it is ST_IDLE.
- ST_READ: mem_we=0.
  - mem_addr = row*800 + col, computed as (row<<9)+(row<<8)+(row<<5)+col.
  - Use AW-bit arithmetic with no truncation, since the maximum is 479999.
- ST_WRITE:
  - If in range: mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1.
  - If out of range: mem_we=0, wr_ack=1, wr_err=1.
- ST_IDLE: mem_we=0; mem_addr holds its previous value.
- Write throughput: wr_req is ignored in the cycle wr_ack=1, so there is at most one write every 2 cycles. This prevents a double write when the requester drops wr_req late.
- Display never stalls. A pending write waits until ready falls, with no timeout.
- Write gate: open whenever ready=0, unless VGA_ARB_VBLANK_ONLY_EN is defined (see Configuration).
- Fetch pipeline: a valid bit follows ST_READ by one cycle, and pixel_data is registered from mem_rdata when that bit is set.

## Timing
- Reset values: mem_addr=0, mem_we=0, mem_wdata=0, wr_ack=0, wr_err=0, pixel_data=0, pixel_valid=0, hsync_out=1, vsync_out=1, FSM=ST_IDLE, vblank flag=0, pipeline valid=0.
- Reset asserted mid-write: the cycle after the rst_n=0 sample has mem_we=0 and wr_ack=0. The requester must re-issue; no partial ack.
- Latency:
  - ready sampled high at edge N gives mem_addr at N+1 and pixel_valid/pixel_data at N+2.
  - hsync_out/vsync_out use the same 2-cycle delay.
  - An 800-cycle ready burst yields exactly 800 consecutive pixel_valid cycles, shifted by 2.
- Write: wr_req seen high at edge N (gate open, ready=0) gives mem_we and wr_ack at N+1.
- Simultaneous ready=1 and wr_req=1: the read wins and wr_ack stays 0.
- ready rising while a write is in ST_WRITE: that write completes, and the read starts the following cycle with no lost pixel, because the state was decided one cycle earlier.

## Configuration
- VGA_ARB_VBLANK_ONLY_EN defined:
  - The write gate is the vblank flag.
  - The flag sets on the cycle after vsnyc_sig=0 is sampled and clears on the first ready=1.
  - Writes are confined to vertical blanking, giving a tear-free frame.
- Not defined: the gate is !ready, so writes also run in horizontal blanking.

## Test plan
- Reset, then one full frame with no writes: pixel_valid high for exactly 480000 cycles per frame. First fetch has mem_addr=0, last has 479999. Each pixel_valid edge lags ready by 2 cycles; hsync_out/vsync_out lag their inputs by 2.
- Preload RAM with data=address[15:0], then run one frame: pixel at row 1, column 0 equals 800; row 599, column 799 equals 479999 & 16'hFFFF.
- wr_req held high with wr_addr=1234 during active video: no wr_ack while ready=1. After ready falls, wr_ack and mem_we are asserted 1 cycle later with mem_addr=1234, exactly once.
- wr_req held continuously across a blanking interval: wr_ack pulses no faster than every other cycle, and mem_we never coincides with a read cycle.
- wr_addr=480000: wr_ack=1 and wr_err=1 in the same cycle, mem_we=0.
- With VGA_ARB_VBLANK_ONLY_EN: a write requested in horizontal blanking is held until after the vsnyc_sig low pulse. Without the macro, the same write is acked in that horizontal blanking.
- rst_n driven low during the ST_WRITE cycle: no wr_ack, all outputs at their reset values after the next edge.
